// File: rtl/d_bch_cs_scheduler_pkg.sv
// Shared definitions for the Chien-search batching scheduler:
// state encoding, default tag width and a ceil-log2 helper.
package d_bch_cs_pkg;

  localparam int DEFAULT_TAG_W = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_RUN     = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // Ceiling log2, at least 1 so it can size a vector directly
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result < 1) result = 1;
    return result;
  endfunction

endpackage

// File: rtl/d_bch_cs_scheduler_if.sv
// Job hand-off channel from the key-equation solver to the scheduler.
interface d_bch_cs_scheduler_if
  import d_bch_cs_pkg::*;
#(
  parameter int TAG_W = DEFAULT_TAG_W
);
  logic             i_job_valid;
  logic             o_job_ready;
  logic             i_job_fwd;
  logic [TAG_W-1:0] i_job_tag;
  logic             i_job_last;

  modport master (
    output i_job_valid, i_job_fwd, i_job_tag, i_job_last,
    input  o_job_ready
  );

  modport slave (
    input  i_job_valid, i_job_fwd, i_job_tag, i_job_last,
    output o_job_ready
  );
endinterface

// File: rtl/d_bch_cs_scheduler_cmplt_tracker.sv
// Per-lane sticky completion flags for one running batch, plus the
// all-lanes-finished reduce. A pulse in the current cycle already counts
// toward all-done, so a batch can finish the cycle after its last pulse.
module d_bch_cs_cmplt_tracker #(
  parameter int Multi = 2
) (
  input  logic             i_clk,
  input  logic             i_RESET,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [Multi-1:0] i_cmplt,
  output logic             o_all_done
);
  logic [Multi-1:0] flags_q;
  logic [Multi-1:0] flags_d;

  // Clear on launch, otherwise accumulate pulses while the batch runs
  always_comb begin
    flags_d = flags_q;
    if (i_clear) flags_d = '0;
    else if (i_enable) flags_d = flags_q | i_cmplt;
  end

  // Flag register
  always_ff @(posedge i_clk) begin
    if (i_RESET) flags_q <= '0;
    else flags_q <= flags_d;
  end

  assign o_all_done = i_enable && (&(flags_q | i_cmplt));
endmodule

// File: rtl/d_bch_cs_scheduler.sv
// Batching scheduler in front of the multi-lane Chien-search array.
// Collects up to Multi jobs, launches the array once, waits for every
// lane to finish and reports the batch. Optional watchdog enabled by
// defining BCH_CS_SCHED_TIMEOUT_EN (adds the sticky o_timeout port).
module d_bch_cs_scheduler
  import d_bch_cs_pkg::*;
#(
  parameter int Multi       = 2,
  parameter int TAG_W       = DEFAULT_TAG_W,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_RESET,
  d_bch_cs_scheduler_if.slave    job_if,
  output logic [Multi-1:0]       o_coef_load,
  input  logic                   i_cs_available,
  output logic                   o_exe_cs,
  output logic [Multi-1:0]       o_data_fowarding,
  input  logic [Multi-1:0]       i_c_message_output_cmplt,
  output logic                   o_batch_done,
  output logic [Multi-1:0]       o_batch_mask,
  output logic [Multi*TAG_W-1:0] o_batch_tags,
  output logic                   o_busy
`ifdef BCH_CS_SCHED_TIMEOUT_EN
  ,
  output logic                   o_timeout
`endif
);
  localparam int CNT_W = clog2(Multi + 1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [Multi-1:0]       mask_q, mask_d;
  logic [Multi-1:0]       fwd_q, fwd_d;
  logic [Multi*TAG_W-1:0] tags_q, tags_d;
  logic                   job_ready_q, job_ready_d;
  logic [Multi-1:0]       coef_load_q, coef_load_d;
  logic                   exe_cs_q, exe_cs_d;
  logic [Multi-1:0]       data_fwd_q, data_fwd_d;
  logic                   batch_done_q, batch_done_d;
  logic [Multi-1:0]       batch_mask_q, batch_mask_d;
  logic [Multi*TAG_W-1:0] batch_tags_q, batch_tags_d;
  logic                   busy_q, busy_d;
  logic                   accept;
  logic                   launch;
  logic                   all_done;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
  localparam int RUN_CNT_W = clog2(TIMEOUT_CYC + 1);
  logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic                   timeout_q, timeout_d;
`endif

  assign accept = job_if.i_job_valid && job_ready_q;

  d_bch_cs_cmplt_tracker #(.Multi(Multi)) u_tracker (
    .i_clk      (i_clk),
    .i_RESET    (i_RESET),
    .i_clear    (launch),
    .i_enable   (state_q == ST_RUN),
    .i_cmplt    (i_c_message_output_cmplt),
    .o_all_done (all_done)
  );

  // Next-state and registered-output computation for the batch FSM
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mask_d       = mask_q;
    fwd_d        = fwd_q;
    tags_d       = tags_q;
    coef_load_d  = '0;
    exe_cs_d     = 1'b0;
    data_fwd_d   = data_fwd_q;
    batch_done_d = 1'b0;
    batch_mask_d = batch_mask_q;
    batch_tags_d = batch_tags_q;
    launch       = 1'b0;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
    run_cnt_d    = run_cnt_q;
    timeout_d    = timeout_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          for (int k = 0; k < Multi; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              fwd_d[k]                 = job_if.i_job_fwd;
              tags_d[k*TAG_W +: TAG_W] = job_if.i_job_tag;
              mask_d[k]                = 1'b1;
              coef_load_d[k]           = 1'b1;
            end
          end
          cnt_d = cnt_q + CNT_W'(1);
          if ((cnt_d == CNT_W'(Multi)) || job_if.i_job_last) begin
            state_d    = ST_LAUNCH;
            data_fwd_d = (fwd_d & mask_d) | ~mask_d;
          end
        end
      end
      ST_LAUNCH: begin
        if (i_cs_available) begin
          exe_cs_d     = 1'b1;
          launch       = 1'b1;
          state_d      = ST_RUN;
          batch_mask_d = '0;
          batch_tags_d = '0;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
          run_cnt_d    = '0;
`endif
        end
      end
      ST_RUN: begin
        if (all_done) begin
          state_d      = ST_DONE;
          batch_done_d = 1'b1;
          batch_mask_d = mask_q;
          batch_tags_d = tags_q;
        end
`ifdef BCH_CS_SCHED_TIMEOUT_EN
        else if (run_cnt_q == RUN_CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d      = ST_DONE;
          batch_done_d = 1'b1;
          batch_mask_d = mask_q;
          batch_tags_d = tags_q;
          timeout_d    = 1'b1;
        end else begin
          run_cnt_d = run_cnt_q + RUN_CNT_W'(1);
        end
`endif
      end
      ST_DONE: begin
        state_d = ST_COLLECT;
        cnt_d   = '0;
        mask_d  = '0;
        fwd_d   = '0;
        tags_d  = '0;
      end
      default: state_d = ST_COLLECT;
    endcase
    job_ready_d = (state_d == ST_COLLECT);
    busy_d      = (state_d != ST_COLLECT) || (cnt_d != '0);
  end

  // State, lane storage and output registers
  always_ff @(posedge i_clk) begin
    if (i_RESET) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= '0;
      mask_q       <= '0;
      fwd_q        <= '0;
      tags_q       <= '0;
      job_ready_q  <= 1'b0;
      coef_load_q  <= '0;
      exe_cs_q     <= 1'b0;
      data_fwd_q   <= '1;
      batch_done_q <= 1'b0;
      batch_mask_q <= '0;
      batch_tags_q <= '0;
      busy_q       <= 1'b0;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
      run_cnt_q    <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mask_q       <= mask_d;
      fwd_q        <= fwd_d;
      tags_q       <= tags_d;
      job_ready_q  <= job_ready_d;
      coef_load_q  <= coef_load_d;
      exe_cs_q     <= exe_cs_d;
      data_fwd_q   <= data_fwd_d;
      batch_done_q <= batch_done_d;
      batch_mask_q <= batch_mask_d;
      batch_tags_q <= batch_tags_d;
      busy_q       <= busy_d;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
      run_cnt_q    <= run_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign job_if.o_job_ready = job_ready_q;
  assign o_coef_load        = coef_load_q;
  assign o_exe_cs           = exe_cs_q;
  assign o_data_fowarding   = data_fwd_q;
  assign o_batch_done       = batch_done_q;
  assign o_batch_mask       = batch_mask_q;
  assign o_batch_tags       = batch_tags_q;
  assign o_busy             = busy_q;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
  assign o_timeout          = timeout_q;
`endif
endmodule

// File: tb/tb_d_bch_cs_scheduler.sv
// Directed bench for the Chien-search batching scheduler (Multi=2, TAG_W=4).
// Expected values are hand-derived; outputs are sampled 1 time unit after
// each rising edge. The watchdog scenario builds only with
// BCH_CS_SCHED_TIMEOUT_EN defined.
module tb_d_bch_cs_scheduler;
  logic       clk = 1'b0;
  logic       rst;
  logic       cs_available;
  logic [1:0] cmplt;
  logic [1:0] coef_load;
  logic       exe_cs;
  logic [1:0] data_fwd;
  logic       batch_done;
  logic [1:0] batch_mask;
  logic [7:0] batch_tags;
  logic       busy;
`ifdef BCH_CS_SCHED_TIMEOUT_EN
  logic       timeout;
`endif

  int check_count = 0;
  int pass_count  = 0;

  d_bch_cs_scheduler_if #(.TAG_W(4)) job_if ();

  d_bch_cs_scheduler #(.Multi(2), .TAG_W(4), .TIMEOUT_CYC(16)) dut (
    .i_clk                    (clk),
    .i_RESET                  (rst),
    .job_if                   (job_if),
    .o_coef_load              (coef_load),
    .i_cs_available           (cs_available),
    .o_exe_cs                 (exe_cs),
    .o_data_fowarding         (data_fwd),
    .i_c_message_output_cmplt (cmplt),
    .o_batch_done             (batch_done),
    .o_batch_mask             (batch_mask),
    .o_batch_tags             (batch_tags),
    .o_busy                   (busy)
`ifdef BCH_CS_SCHED_TIMEOUT_EN
    ,
    .o_timeout                (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Offer one job, waiting (bounded) for ready; returns just after the accept edge
  task automatic applyStimulus(input logic fwd, input logic [3:0] tag, input logic last);
    int wait_cyc;
    wait_cyc = 0;
    while (job_if.o_job_ready !== 1'b1 && wait_cyc < 50) begin
      tick();
      wait_cyc++;
    end
    if (wait_cyc >= 50) checkOutput("ready_wait_timeout", 32'd0, 32'd1);
    job_if.i_job_valid = 1'b1;
    job_if.i_job_fwd   = fwd;
    job_if.i_job_tag   = tag;
    job_if.i_job_last  = last;
    tick();
    job_if.i_job_valid = 1'b0;
    job_if.i_job_last  = 1'b0;
  endtask

  initial begin
    int exe_seen;
    int ready_seen;
    int done_seen;
    int cyc;

    rst = 1'b1;
    cs_available = 1'b1;
    cmplt = 2'b00;
    job_if.i_job_valid = 1'b0;
    job_if.i_job_fwd   = 1'b0;
    job_if.i_job_tag   = 4'h0;
    job_if.i_job_last  = 1'b0;
    tick();
    tick();

    // Reset values
    checkOutput("rst_ready", {31'd0, job_if.o_job_ready}, 32'd0);
    checkOutput("rst_coef", {30'd0, coef_load}, 32'd0);
    checkOutput("rst_exe", {31'd0, exe_cs}, 32'd0);
    checkOutput("rst_fwd", {30'd0, data_fwd}, 32'h3);
    checkOutput("rst_done", {31'd0, batch_done}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("ready_after_rst", {31'd0, job_if.o_job_ready}, 32'd1);

    // Batch 1: two jobs filling both lanes
    applyStimulus(1'b0, 4'h3, 1'b0);
    checkOutput("b1_coef0", {30'd0, coef_load}, 32'h1);
    checkOutput("b1_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 4'h5, 1'b0);
    checkOutput("b1_coef1", {30'd0, coef_load}, 32'h2);
    checkOutput("b1_ready_low", {31'd0, job_if.o_job_ready}, 32'd0);
    checkOutput("b1_fwd", {30'd0, data_fwd}, 32'h2);
    checkOutput("b1_exe_early", {31'd0, exe_cs}, 32'd0);
    tick();
    checkOutput("b1_exe", {31'd0, exe_cs}, 32'd1);
    tick();
    checkOutput("b1_exe_once", {31'd0, exe_cs}, 32'd0);
    cmplt = 2'b01;
    tick();
    cmplt = 2'b00;
    checkOutput("b1_done_early", {31'd0, batch_done}, 32'd0);
    cmplt = 2'b10;
    tick();
    cmplt = 2'b00;
    checkOutput("b1_done", {31'd0, batch_done}, 32'd1);
    checkOutput("b1_mask", {30'd0, batch_mask}, 32'h3);
    checkOutput("b1_tags", {24'd0, batch_tags}, 32'h53);
    tick();
    checkOutput("b1_done_pulse", {31'd0, batch_done}, 32'd0);
    checkOutput("b1_ready_back", {31'd0, job_if.o_job_ready}, 32'd1);
    checkOutput("b1_mask_hold", {30'd0, batch_mask}, 32'h3);

    // Batch 2: single job closed with last; unused lane forced to forward
    applyStimulus(1'b0, 4'h7, 1'b1);
    checkOutput("b2_coef", {30'd0, coef_load}, 32'h1);
    checkOutput("b2_fwd", {30'd0, data_fwd}, 32'h2);
    checkOutput("b2_mask_hold", {30'd0, batch_mask}, 32'h3);
    tick();
    checkOutput("b2_exe", {31'd0, exe_cs}, 32'd1);
    cmplt = 2'b01;
    tick();
    cmplt = 2'b00;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (batch_done) done_seen++;
    end
    checkOutput("b2_wait_lane1", done_seen, 0);
    cmplt = 2'b10;
    tick();
    cmplt = 2'b00;
    checkOutput("b2_done", {31'd0, batch_done}, 32'd1);
    checkOutput("b2_mask", {30'd0, batch_mask}, 32'h1);
    checkOutput("b2_tags", {24'd0, batch_tags}, 32'h07);

    // Batch 3: array unavailable for 20 cycles, stale pulses ignored
    cs_available = 1'b0;
    applyStimulus(1'b1, 4'h9, 1'b1);
    checkOutput("b3_fwd", {30'd0, data_fwd}, 32'h3);
    exe_seen = 0;
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cmplt = (i == 5 || i == 10) ? 2'b11 : 2'b00;
      tick();
      if (exe_cs) exe_seen++;
      if (job_if.o_job_ready) ready_seen++;
    end
    cmplt = 2'b00;
    checkOutput("b3_no_exe", exe_seen, 0);
    checkOutput("b3_no_ready", ready_seen, 0);
    cs_available = 1'b1;
    tick();
    checkOutput("b3_exe", {31'd0, exe_cs}, 32'd1);
    exe_seen = 0;
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (exe_cs) exe_seen++;
      if (batch_done) done_seen++;
    end
    checkOutput("b3_single_exe", exe_seen, 0);
    checkOutput("b3_stale_ignored", done_seen, 0);
    cmplt = 2'b11;
    tick();
    cmplt = 2'b00;
    checkOutput("b3_done", {31'd0, batch_done}, 32'd1);

    // Batch 4: completions on the launch cycle itself
    applyStimulus(1'b0, 4'h2, 1'b0);
    applyStimulus(1'b0, 4'h4, 1'b0);
    checkOutput("b4_fwd", {30'd0, data_fwd}, 32'h0);
    tick();
    checkOutput("b4_exe", {31'd0, exe_cs}, 32'd1);
    cmplt = 2'b11;
    tick();
    cmplt = 2'b00;
    checkOutput("b4_done", {31'd0, batch_done}, 32'd1);
    checkOutput("b4_tags", {24'd0, batch_tags}, 32'h42);

    // Batch 5: reset in RUN aborts it
    applyStimulus(1'b0, 4'h6, 1'b1);
    tick();
    checkOutput("b5_exe", {31'd0, exe_cs}, 32'd1);
    cmplt = 2'b01;
    tick();
    cmplt = 2'b00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("b5_rst_done", {31'd0, batch_done}, 32'd0);
    checkOutput("b5_rst_fwd", {30'd0, data_fwd}, 32'h3);
    checkOutput("b5_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("b5_rst_mask", {30'd0, batch_mask}, 32'h0);
    checkOutput("b5_rst_tags", {24'd0, batch_tags}, 32'h0);
    checkOutput("b5_rst_ready", {31'd0, job_if.o_job_ready}, 32'd0);
    cmplt = 2'b10;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmplt = 2'b00;
      if (batch_done) done_seen++;
    end
    checkOutput("b5_no_done", done_seen, 0);

    // Batch 6: normal batch after the abort
    applyStimulus(1'b1, 4'hA, 1'b0);
    applyStimulus(1'b0, 4'hB, 1'b0);
    checkOutput("b6_fwd", {30'd0, data_fwd}, 32'h1);
    tick();
    checkOutput("b6_exe", {31'd0, exe_cs}, 32'd1);
    cmplt = 2'b10;
    tick();
    cmplt = 2'b01;
    tick();
    cmplt = 2'b00;
    checkOutput("b6_done", {31'd0, batch_done}, 32'd1);
    checkOutput("b6_mask", {30'd0, batch_mask}, 32'h3);
    checkOutput("b6_tags", {24'd0, batch_tags}, 32'hBA);

`ifdef BCH_CS_SCHED_TIMEOUT_EN
    // Watchdog: only lane 0 finishes, done forced after 16 RUN cycles
    applyStimulus(1'b0, 4'h1, 1'b1);
    tick();
    checkOutput("to_exe", {31'd0, exe_cs}, 32'd1);
    checkOutput("to_clear", {31'd0, timeout}, 32'd0);
    cmplt = 2'b01;
    cyc = 0;
    while (batch_done !== 1'b1 && cyc < 40) begin
      tick();
      cmplt = 2'b00;
      cyc++;
    end
    checkOutput("to_cycles", cyc, 16);
    checkOutput("to_flag", {31'd0, timeout}, 32'd1);
    checkOutput("to_mask", {30'd0, batch_mask}, 32'h1);
    tick();
    tick();
    checkOutput("to_sticky", {31'd0, timeout}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("to_rst", {31'd0, timeout}, 32'd0);
`else
    cyc = 0;
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end
endmodule
